// File: rtl/dual_core_mem_arbiter.sv
// Round-robin arbiter sharing one byte-wide synchronous memory port between two mips cores.
// Optional burst lock (keep the grant for up to BURST_LEN accesses) enabled by ARB_BURST_LOCK_EN.
module dual_core_mem_arbiter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ADR_W     = 8,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memread0,
    input  logic             memwrite0,
    input  logic [ADR_W-1:0] adr0,
    input  logic [WIDTH-1:0] writedata0,
    output logic [WIDTH-1:0] memdata0,
    output logic             ready0,
    input  logic             memread1,
    input  logic             memwrite1,
    input  logic [ADR_W-1:0] adr1,
    input  logic [WIDTH-1:0] writedata1,
    output logic [WIDTH-1:0] memdata1,
    output logic             ready1,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [ADR_W-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

    state_e             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               op_wr_q, op_wr_d;
    logic               mem_rd_q, mem_rd_d;
    logic               mem_wr_q, mem_wr_d;
    logic [ADR_W-1:0]   mem_adr_q, mem_adr_d;
    logic [WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

    logic req0, req1, hold, win;

    assign req0 = memread0 | memwrite0;
    assign req1 = memread1 | memwrite1;

`ifdef ARB_BURST_LOCK_EN
    localparam int unsigned LockW = $clog2(BURST_LEN + 1);

    logic [LockW-1:0] lock_cnt_q, lock_cnt_d;
    logic             holder_req;

    assign holder_req = last_grant_q ? req1 : req0;
    // The last winner keeps a tie while it still requests and has burst budget left.
    assign hold = holder_req && (lock_cnt_q != '0) && (lock_cnt_q < LockW'(BURST_LEN));

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (state_q == StIdle) begin
            if (!holder_req) begin
                lock_cnt_d = '0;
            end
            if (req0 || req1) begin
                if ((win == last_grant_q) && (lock_cnt_q != '0)) begin
                    // Saturate so an exhausted lock stays released until the other core wins.
                    lock_cnt_d = (lock_cnt_q == LockW'(BURST_LEN)) ? lock_cnt_q
                                                                   : lock_cnt_q + LockW'(1);
                end else begin
                    lock_cnt_d = LockW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_cnt_q <= '0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
        end
    end
`else
    logic unused_burst_len;
    assign unused_burst_len = (BURST_LEN != 0);
    assign hold = 1'b0;
`endif

    // A single requester always wins; a tie goes to the other core unless locked.
    assign win = (req0 && req1) ? (hold ? last_grant_q : ~last_grant_q) : req1;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_wr_d      = op_wr_q;
        mem_rd_d     = 1'b0;
        mem_wr_d     = 1'b0;
        mem_adr_d    = mem_adr_q;
        mem_wdata_d  = mem_wdata_q;
        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    state_d      = StIssue;
                    last_grant_d = win;
                    // Read and write together resolves to a write.
                    op_wr_d      = win ? memwrite1 : memwrite0;
                    mem_wr_d     = op_wr_d;
                    mem_rd_d     = ~op_wr_d;
                    mem_adr_d    = win ? adr1 : adr0;
                    mem_wdata_d  = win ? writedata1 : writedata0;
                end
            end
            StIssue: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            op_wr_q      <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_adr_q    <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_wr_q      <= op_wr_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            mem_adr_q    <= mem_adr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_adr   = mem_adr_q;
    assign mem_wdata = mem_wdata_q;

    assign ready0   = (state_q == StDone) && !last_grant_q;
    assign ready1   = (state_q == StDone) &&  last_grant_q;
    assign memdata0 = (ready0 && !op_wr_q) ? mem_rdata : '0;
    assign memdata1 = (ready1 && !op_wr_q) ? mem_rdata : '0;

endmodule
